// File: rtl/ps_if_arbiter_pkg.sv
// Shared types and helpers for the ps_if register-port arbiter.
package ps_if_arbiter_pkg;

  // Arbiter FSM states; IDLE is the only state in which the port is free.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD      = 2'd3
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_if_arbiter_if.sv
// ps_if register port bundle. NP=N for the flattened upstream side, NP=1
// for the single downstream port. rdata is shared across all NP slices.
//
// Handshake: a write is accepted on the cycle wvalid && wready are both high
// and completes on wresp; a read request (arvalid) is held until rvalid && rready,
// on which cycle rdata is taken. Requesters must not drop a valid once raised
// unless they mean to abandon the transaction.
interface ps_if_arbiter_if #(
  parameter int NP     = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NP*ADDR_W-1:0] waddr;
  logic [NP*DATA_W-1:0] wdata;
  logic [NP-1:0]        wvalid;
  logic [NP-1:0]        wready;
  logic [NP-1:0]        wresp;
  logic [NP*ADDR_W-1:0] raddr;
  logic [NP-1:0]        arvalid;
  logic [DATA_W-1:0]    rdata;
  logic [NP-1:0]        rvalid;
  logic [NP-1:0]        rready;

  // Side that issues transactions.
  modport master (
    output waddr, wdata, wvalid, raddr, arvalid, rready,
    input  wready, wresp, rdata, rvalid
  );

  // Side that serves transactions.
  modport slave (
    input  waddr, wdata, wvalid, raddr, arvalid, rready,
    output wready, wresp, rdata, rvalid
  );
endinterface

// File: rtl/ps_if_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping at N.
module rr_arbiter
  import ps_if_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // Scan last_grant+1 .. last_grant+N (mod N); the first hit wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh = found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/ps_if_arbiter.sv
// Shares one downstream ps_if register port between N requesters.
// A grant is held for one whole transaction (write through wresp, or read
// through rvalid); a watchdog frees the port if the downstream hangs.
module ps_if_arbiter
  import ps_if_arbiter_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int WRESP_EN = 1,
  parameter  int TIMEOUT  = 255,
  localparam int IW       = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  ps_if_arbiter_if.slave        s,
  ps_if_arbiter_if.master       m,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout_err,
  output arb_state_t            dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IW-1:0]     last_grant;
  logic [TW-1:0]     timer;
  logic [N-1:0]      req;
  logic [N-1:0]      arb_oh;
  logic [IW-1:0]     arb_idx;
  logic              arb_found;
  logic              done;
  logic              to_resp;
  logic              drop;
  logic              tmo;
  logic [ADDR_W-1:0] waddr_a [N];
  logic [DATA_W-1:0] wdata_a [N];
  logic [ADDR_W-1:0] raddr_a [N];

  // Unflatten the per-requester address/data slices.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign waddr_a[gi] = s.waddr[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = s.wdata[gi*DATA_W +: DATA_W];
    assign raddr_a[gi] = s.raddr[gi*ADDR_W +: ADDR_W];
  end

  assign req       = s.wvalid | s.arvalid;
  assign dbg_state = state;

  rr_arbiter #(.N(N)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_oh     (arb_oh),
    .gnt_idx    (arb_idx),
    .found      (arb_found)
  );

  // Downstream mux and one-hot response demux, driven from the registered owner.
  always_comb begin
    m.waddr   = '0;
    m.wdata   = '0;
    m.wvalid  = '0;
    m.raddr   = '0;
    m.arvalid = '0;
    m.rready  = '0;
    s.wready  = '0;
    s.wresp   = '0;
    s.rvalid  = '0;
    s.rdata   = '0;
    done      = 1'b0;
    to_resp   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      WR_DATA: begin
        m.waddr            = waddr_a[grant_id];
        m.wdata            = wdata_a[grant_id];
        m.wvalid[0]        = s.wvalid[grant_id];
        s.wready[grant_id] = s.wvalid[grant_id] & m.wready[0];
        if (WRESP_EN != 0) begin
          to_resp = s.wready[grant_id];
        end else begin
          s.wresp[grant_id] = s.wready[grant_id];
          done              = s.wready[grant_id];
        end
        drop = !s.wvalid[grant_id];
      end
      WR_RESP: begin
        s.wresp[grant_id] = m.wresp[0];
        done              = m.wresp[0];
      end
      RD: begin
        m.raddr            = raddr_a[grant_id];
        m.arvalid[0]       = s.arvalid[grant_id];
        m.rready[0]        = s.rready[grant_id];
        s.rvalid[grant_id] = m.rvalid[0] & s.rready[grant_id];
        if (s.rvalid[grant_id]) s.rdata = m.rdata;
        done = s.rvalid[grant_id];
        drop = !s.arvalid[grant_id] && !s.rvalid[grant_id];
      end
      default: ;
    endcase
    // Last allowed cycle: a completion or a quiet drop takes priority over the abort.
    tmo = (state != IDLE) && (timer == TW'(TIMEOUT - 1)) && !done && !drop;
  end

  assign timeout_err = tmo;

  // Arbitration, ownership and watchdog state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(N - 1);
      timer      <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id   <= arb_idx;
            last_grant <= arb_idx;
            timer      <= '0;
            busy       <= 1'b1;
            // A requester raising both valids gets its write first.
            state      <= (|(arb_oh & s.wvalid)) ? WR_DATA : RD;
          end
        end
        default: begin
          timer <= timer + TW'(1);
          if (done || drop || tmo) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (to_resp) begin
            state <= WR_RESP;
          end
        end
      endcase
    end
  end

endmodule
